// File: rtl/z80fi_call_ret_monitor.sv
// Shadow return-stack monitor for a Z80 retirement trace: CALL/RST push, RET/RETI/RETN pop and compare.
// Optional macro Z80FI_RST_TRACK_EN: when defined, RST p is tracked as a push with retaddr = ip_in + 1.
module z80fi_call_ret_monitor #(
    parameter int DEPTH    = 16,
    parameter int SP_CHECK = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     z80fi_valid,
    input  logic [31:0]              z80fi_insn,
    input  logic [2:0]               z80fi_insn_len,
    input  logic [15:0]              z80fi_reg_ip_in,
    input  logic [15:0]              z80fi_reg_ip_out,
    input  logic [15:0]              z80fi_reg_sp_in,
    input  logic [15:0]              z80fi_reg_sp_out,
    input  logic                     track_clear,
    output logic                     ret_mismatch,
    output logic                     sp_mismatch,
    output logic                     underflow,
    output logic                     overflowed,
    output logic [$clog2(DEPTH):0]   depth,
    output logic [15:0]              top_addr
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_ACTIVE, ST_FULL} state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   depth_nxt;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   top_idx, below_idx;
    logic [15:0]     ret_mem [DEPTH];
    logic [15:0]     sp_mem  [DEPTH];

    logic [7:0]      op;
    logic            is_push, is_pop, push_ev, pop_ev;
    logic [15:0]     push_ret;
    logic            insn_hi_unused;

    assign op             = z80fi_insn[7:0];
    assign insn_hi_unused = ^z80fi_insn[31:16];
    assign top_idx        = wptr - PW'(1);
    assign below_idx      = wptr - PW'(2);

    // Instruction classification; conditional forms count only when SP moved by a full frame
    always_comb begin
        is_push  = 1'b0;
        is_pop   = 1'b0;
        push_ret = z80fi_reg_ip_in + {13'd0, z80fi_insn_len};
        if (op == 8'hCD) begin
            is_push = 1'b1;
        end else if (op[7:6] == 2'b11 && op[2:0] == 3'b100) begin
            is_push = (z80fi_reg_sp_out == z80fi_reg_sp_in - 16'd2);
`ifdef Z80FI_RST_TRACK_EN
        end else if (op[7:6] == 2'b11 && op[2:0] == 3'b111) begin
            is_push  = 1'b1;
            push_ret = z80fi_reg_ip_in + 16'd1;
`endif
        end else if (op == 8'hC9) begin
            is_pop = 1'b1;
        end else if (op[7:6] == 2'b11 && op[2:0] == 3'b000) begin
            is_pop = (z80fi_reg_sp_out == z80fi_reg_sp_in + 16'd2);
        end else if (z80fi_insn_len == 3'd2 &&
                     (z80fi_insn[15:0] == 16'h4DED || z80fi_insn[15:0] == 16'h45ED)) begin
            is_pop = 1'b1;
        end
    end

    assign push_ev = z80fi_valid && !track_clear && is_push;
    assign pop_ev  = z80fi_valid && !track_clear && is_pop;

    always_comb begin
        state_nxt = state;
        depth_nxt = depth;
        if (track_clear) begin
            state_nxt = ST_EMPTY;
            depth_nxt = '0;
        end else if (push_ev) begin
            case (state)
                ST_EMPTY: begin
                    state_nxt = ST_ACTIVE;
                    depth_nxt = DW'(1);
                end
                ST_ACTIVE: begin
                    depth_nxt = depth + DW'(1);
                    if (depth == DW'(DEPTH - 1)) state_nxt = ST_FULL;
                end
                default: state_nxt = ST_FULL;
            endcase
        end else if (pop_ev) begin
            case (state)
                ST_FULL: begin
                    state_nxt = ST_ACTIVE;
                    depth_nxt = depth - DW'(1);
                end
                ST_ACTIVE: begin
                    depth_nxt = depth - DW'(1);
                    if (depth == DW'(1)) state_nxt = ST_EMPTY;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_EMPTY;
            depth        <= '0;
            wptr         <= '0;
            overflowed   <= 1'b0;
            top_addr     <= 16'h0000;
            ret_mismatch <= 1'b0;
            sp_mismatch  <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state        <= state_nxt;
            depth        <= depth_nxt;
            ret_mismatch <= 1'b0;
            sp_mismatch  <= 1'b0;
            underflow    <= 1'b0;
            if (track_clear) begin
                wptr       <= '0;
                overflowed <= 1'b0;
                top_addr   <= 16'h0000;
            end else if (push_ev) begin
                // When full, wptr already points at the oldest entry, so it is overwritten
                wptr     <= wptr + PW'(1);
                top_addr <= push_ret;
                if (state == ST_FULL) overflowed <= 1'b1;
            end else if (pop_ev) begin
                if (state == ST_EMPTY) begin
                    underflow <= 1'b1;
                end else begin
                    ret_mismatch <= (z80fi_reg_ip_out != ret_mem[top_idx]);
                    sp_mismatch  <= (SP_CHECK != 0) && (z80fi_reg_sp_in != sp_mem[top_idx]);
                    wptr         <= top_idx;
                    top_addr     <= (state_nxt == ST_EMPTY) ? 16'h0000 : ret_mem[below_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ev) begin
            ret_mem[wptr] <= push_ret;
            sp_mem[wptr]  <= z80fi_reg_sp_out;
        end
    end

endmodule
